game_sprite_mover: RTL and testbench

GAME_SPRITE_MOVER -- requirements
Module: game_sprite_mover

---
 rtl/game_pkg.sv | 21 ++
 rtl/game_axis_step.sv | 30 +++
 rtl/game_sprite_mover.sv | 153 +++++++++++++++
 tb/tb_game_sprite_mover.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared types and constants for the sprite mover: FSM state encoding and
// velocity width, plus the capture-time velocity clamp.
package game_pkg;

    localparam int VEL_W = 4;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_MOVING = 2'd1,
        S_HIT    = 2'd2
    } state_t;

    localparam logic signed [VEL_W-1:0] VEL_MIN    = {1'b1, {(VEL_W-1){1'b0}}};
    localparam logic signed [VEL_W-1:0] VEL_MIN_P1 = {1'b1, {(VEL_W-2){1'b0}}, 1'b1};

    // The most negative velocity has no positive twin; fold it so a bounce can always negate.
    function automatic logic signed [VEL_W-1:0] sat_vel(input logic signed [VEL_W-1:0] v);
        return (v == VEL_MIN) ? VEL_MIN_P1 : v;
    endfunction

endpackage

// File: rtl/game_axis_step.sv
// One axis of sprite motion: adds velocity to position with one spare bit,
// clamps to [lo, hi] and reverses velocity when either limit is crossed.
module game_axis_step
    import game_pkg::*;
#(
    parameter int W = 10
) (
    input  logic [W-1:0]            i_pos,
    input  logic signed [VEL_W-1:0] i_vel,
    input  logic [W-1:0]            i_lo,
    input  logic [W-1:0]            i_hi,
    output logic [W-1:0]            o_pos,
    output logic signed [VEL_W-1:0] o_vel,
    output logic                    o_hit_low,
    output logic                    o_hit_high
);

    logic signed [W:0] w_sum;
    logic signed [W:0] w_lo;
    logic signed [W:0] w_hi;

    assign w_sum      = $signed({1'b0, i_pos}) + (W+1)'(i_vel);
    assign w_lo       = $signed({1'b0, i_lo});
    assign w_hi       = $signed({1'b0, i_hi});
    assign o_hit_low  = (w_sum < w_lo);
    assign o_hit_high = (w_sum > w_hi);
    assign o_pos      = o_hit_low ? i_lo : (o_hit_high ? i_hi : w_sum[W-1:0]);
    assign o_vel      = (o_hit_low || o_hit_high) ? -i_vel : i_vel;

endmodule

// File: rtl/game_sprite_mover.sv
// Sprite launched from a start point, moving once per frame with wall bounces,
// frozen for a number of frames on collision, and returned home on bottom exit.
module game_sprite_mover
    import game_pkg::*;
#(
    parameter int X_WIDTH    = 10,
    parameter int Y_WIDTH    = 10,
    parameter int SCREEN_W   = 640,
    parameter int SCREEN_H   = 480,
    parameter int SPRITE_W   = 8,
    parameter int SPRITE_H   = 8,
    parameter int START_X    = 316,
    parameter int START_Y    = 0,
    parameter int HIT_FRAMES = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    frame_tick,
    input  logic                    launch,
    input  logic signed [VEL_W-1:0] dx,
    input  logic signed [VEL_W-1:0] dy,
    input  logic                    collision,
    output logic [X_WIDTH-1:0]      left,
    output logic [X_WIDTH-1:0]      right,
    output logic [Y_WIDTH-1:0]      top,
    output logic [Y_WIDTH-1:0]      bottom,
    output logic                    active,
    output logic                    hit,
    output logic                    missed
);

    localparam int CNT_W = $clog2(HIT_FRAMES + 1);
    localparam logic [X_WIDTH-1:0] X_START = X_WIDTH'(START_X);
    localparam logic [Y_WIDTH-1:0] Y_START = Y_WIDTH'(START_Y);
    localparam logic [X_WIDTH-1:0] X_MAX   = X_WIDTH'(SCREEN_W - SPRITE_W);
    localparam logic [Y_WIDTH-1:0] Y_MAX   = Y_WIDTH'(SCREEN_H - SPRITE_H);
    localparam logic [X_WIDTH-1:0] X_SPAN  = X_WIDTH'(SPRITE_W - 1);
    localparam logic [Y_WIDTH-1:0] Y_SPAN  = Y_WIDTH'(SPRITE_H - 1);

    state_t                  r_state;
    logic [X_WIDTH-1:0]      r_x;
    logic [Y_WIDTH-1:0]      r_y;
    logic signed [VEL_W-1:0] r_vx;
    logic signed [VEL_W-1:0] r_vy;
    logic [CNT_W-1:0]        r_cnt;
    logic                    r_miss_evt;
    logic [X_WIDTH-1:0]      r_left, r_right;
    logic [Y_WIDTH-1:0]      r_top, r_bottom;
    logic                    r_active, r_hit, r_missed;

    logic [X_WIDTH-1:0]      w_x_nxt;
    logic [Y_WIDTH-1:0]      w_y_nxt;
    logic signed [VEL_W-1:0] w_vx_nxt, w_vy_nxt;
    logic                    w_x_hit_low, w_x_hit_high, w_y_hit_low, w_y_hit_high;
    logic                    w_unused_hits;

    game_axis_step #(.W(X_WIDTH)) u_x_step (
        .i_pos(r_x), .i_vel(r_vx), .i_lo('0), .i_hi(X_MAX),
        .o_pos(w_x_nxt), .o_vel(w_vx_nxt), .o_hit_low(w_x_hit_low), .o_hit_high(w_x_hit_high)
    );

    // The high limit on y is the bottom exit, not a wall.
    game_axis_step #(.W(Y_WIDTH)) u_y_step (
        .i_pos(r_y), .i_vel(r_vy), .i_lo('0), .i_hi(Y_MAX),
        .o_pos(w_y_nxt), .o_vel(w_vy_nxt), .o_hit_low(w_y_hit_low), .o_hit_high(w_y_hit_high)
    );

    assign w_unused_hits = w_x_hit_low | w_x_hit_high | w_y_hit_low;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_x        <= X_START;
            r_y        <= Y_START;
            r_vx       <= '0;
            r_vy       <= '0;
            r_cnt      <= '0;
            r_miss_evt <= 1'b0;
        end else begin
            r_miss_evt <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_x <= X_START;
                    r_y <= Y_START;
                    if (launch) begin
                        r_vx    <= sat_vel(dx);
                        r_vy    <= sat_vel(dy);
                        r_state <= S_MOVING;
                    end
                end
                S_MOVING: begin
                    if (collision) begin
                        r_state <= S_HIT;
                        r_cnt   <= CNT_W'(HIT_FRAMES);
                    end else if (frame_tick) begin
                        if (w_y_hit_high) begin
                            r_state    <= S_IDLE;
                            r_miss_evt <= 1'b1;
                            r_x        <= X_START;
                            r_y        <= Y_START;
                        end else begin
                            r_x  <= w_x_nxt;
                            r_y  <= w_y_nxt;
                            r_vx <= w_vx_nxt;
                            r_vy <= w_vy_nxt;
                        end
                    end
                end
                S_HIT: begin
                    if (frame_tick) begin
                        r_cnt <= r_cnt - CNT_W'(1);
                        if (r_cnt <= CNT_W'(1)) begin
                            r_state <= S_IDLE;
                            r_x     <= X_START;
                            r_y     <= Y_START;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Output stage trails the state by one edge so every output moves together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_left   <= X_START;
            r_right  <= X_START + X_SPAN;
            r_top    <= Y_START;
            r_bottom <= Y_START + Y_SPAN;
            r_active <= 1'b0;
            r_hit    <= 1'b0;
            r_missed <= 1'b0;
        end else begin
            r_left   <= r_x;
            r_right  <= r_x + X_SPAN;
            r_top    <= r_y;
            r_bottom <= r_y + Y_SPAN;
            r_active <= (r_state == S_MOVING);
            r_hit    <= (r_state == S_HIT);
            r_missed <= r_miss_evt;
        end
    end

    assign left   = r_left;
    assign right  = r_right;
    assign top    = r_top;
    assign bottom = r_bottom;
    assign active = r_active;
    assign hit    = r_hit;
    assign missed = r_missed;

endmodule

// File: tb/tb_game_sprite_mover.sv
// Bench for game_sprite_mover: an abstract per-frame model checked every cycle,
// plus directed scenarios with hand-computed rectangle values.
module tb_game_sprite_mover;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              frame_tick = 1'b0;
    logic              launch = 1'b0;
    logic              collision = 1'b0;
    logic signed [3:0] dx = '0;
    logic signed [3:0] dy = '0;
    logic [9:0]        left, right, top, bottom;
    logic              active, hit, missed;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    game_sprite_mover dut (
        .clk(clk), .reset(reset), .frame_tick(frame_tick), .launch(launch),
        .dx(dx), .dy(dy), .collision(collision),
        .left(left), .right(right), .top(top), .bottom(bottom),
        .active(active), .hit(hit), .missed(missed)
    );

    // mode: 0 idle, 1 moving, 2 hit
    typedef struct {
        int mode; int x; int y; int vx; int vy; int cnt; bit miss;
    } mst_t;

    function automatic mst_t rst_state();
        mst_t s;
        s.mode = 0; s.x = 316; s.y = 0; s.vx = 0; s.vy = 0; s.cnt = 0; s.miss = 1'b0;
        return s;
    endfunction

    function automatic int capv(int v);
        return (v < -7) ? -7 : v;
    endfunction

    function automatic mst_t nxt(mst_t s, bit ft, bit la, bit co, int ddx, int ddy);
        mst_t n;
        int nx, ny;
        n = s;
        n.miss = 1'b0;
        if (s.mode == 0) begin
            n.x = 316; n.y = 0;
            if (la) begin n.vx = capv(ddx); n.vy = capv(ddy); n.mode = 1; end
        end else if (s.mode == 1) begin
            if (co) begin
                n.mode = 2; n.cnt = 16;
            end else if (ft) begin
                nx = s.x + s.vx;
                ny = s.y + s.vy;
                if (ny > 472) begin
                    n.mode = 0; n.miss = 1'b1; n.x = 316; n.y = 0;
                end else begin
                    if (nx < 0) begin nx = 0; n.vx = -s.vx; end
                    else if (nx > 632) begin nx = 632; n.vx = -s.vx; end
                    if (ny < 0) begin ny = 0; n.vy = -s.vy; end
                    n.x = nx; n.y = ny;
                end
            end
        end else if (ft) begin
            n.cnt = s.cnt - 1;
            if (n.cnt == 0) begin n.mode = 0; n.x = 316; n.y = 0; end
        end
        return n;
    endfunction

    mst_t m, e;

    // e is the state the outputs should show: the model state one edge later.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m <= rst_state();
            e <= rst_state();
        end else begin
            e <= m;
            m <= nxt(m, frame_tick, launch, collision, int'(dx), int'(dy));
        end
    end

    task automatic check(string nm, int act, int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at t=%0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            check("model_left",   int'(left),   e.x);
            check("model_right",  int'(right),  e.x + 7);
            check("model_top",    int'(top),    e.y);
            check("model_bottom", int'(bottom), e.y + 7);
            check("model_active", int'(active), int'(e.mode == 1));
            check("model_hit",    int'(hit),    int'(e.mode == 2));
            check("model_missed", int'(missed), int'(e.miss));
        end
    end

    task automatic step(bit ft, bit la, bit co, logic signed [3:0] ddx, logic signed [3:0] ddy);
        frame_tick = ft; launch = la; collision = co; dx = ddx; dy = ddy;
        @(posedge clk); #1;
        frame_tick = 1'b0; launch = 1'b0; collision = 1'b0;
    endtask

    task automatic idle(int n);
        repeat (n) step(1'b0, 1'b0, 1'b0, 4'sd0, 4'sd0);
    endtask

    task automatic tick();
        step(1'b1, 1'b0, 1'b0, 4'sd0, 4'sd0);
        idle(2);
    endtask

    task automatic do_reset();
        reset = 1'b1; #2; reset = 1'b0;
    endtask

    task automatic check_start_rect(string tag);
        check({tag, "_left"},   int'(left),   316);
        check({tag, "_right"},  int'(right),  323);
        check({tag, "_top"},    int'(top),    0);
        check({tag, "_bottom"}, int'(bottom), 7);
        check({tag, "_active"}, int'(active), 0);
        check({tag, "_hit"},    int'(hit),    0);
        check({tag, "_missed"}, int'(missed), 0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check_start_rect("reset");
        reset = 1'b0;

        // collision in IDLE is ignored
        step(1'b0, 1'b0, 1'b1, 4'sd0, 4'sd0);
        idle(2);
        check("idle_coll_hit", int'(hit), 0);

        // launch +3/+2, three frames
        step(1'b0, 1'b1, 1'b0, 4'sd3, 4'sd2);
        repeat (3) tick();
        check("fly_left", int'(left), 325);
        check("fly_right", int'(right), 332);
        check("fly_top", int'(top), 6);
        check("fly_bottom", int'(bottom), 13);
        check("fly_active", int'(active), 1);
        // launch while moving must not change velocity
        step(1'b0, 1'b1, 1'b0, -4'sd5, -4'sd5);
        tick();
        check("relaunch_left", int'(left), 328);
        check("relaunch_top", int'(top), 8);

        // -8 folds to -7; top bounce from y=0
        do_reset();
        step(1'b0, 1'b1, 1'b0, -4'sd8, -4'sd8);
        tick();
        check("neg8_left", int'(left), 309);
        check("topb_top", int'(top), 0);
        tick();
        check("neg8_left2", int'(left), 302);
        check("topb_top2", int'(top), 7);

        // left wall then right wall bounce with |vx|=5
        do_reset();
        step(1'b0, 1'b1, 1'b0, -4'sd5, 4'sd0);
        repeat (63) tick();
        check("lw_pre_left", int'(left), 1);
        tick();
        check("lw_left", int'(left), 0);
        repeat (126) tick();
        check("rw_pre_left", int'(left), 630);
        tick();
        check("rw_left", int'(left), 632);
        check("rw_right", int'(right), 639);
        tick();
        check("rw_back_left", int'(left), 627);

        // bottom exit
        do_reset();
        step(1'b0, 1'b1, 1'b0, 4'sd0, 4'sd7);
        repeat (67) tick();
        check("exit_pre_top", int'(top), 469);
        check("exit_pre_bottom", int'(bottom), 476);
        step(1'b1, 1'b0, 1'b0, 4'sd0, 4'sd0);
        check("exit_edge_missed", int'(missed), 0);
        check("exit_edge_active", int'(active), 1);
        @(posedge clk); #1;
        check("exit_missed", int'(missed), 1);
        check("exit_left", int'(left), 316);
        check("exit_top", int'(top), 0);
        check("exit_active", int'(active), 0);
        @(posedge clk); #1;
        check("exit_missed_end", int'(missed), 0);

        // collision together with frame_tick, then 16 frames of HIT
        do_reset();
        step(1'b0, 1'b1, 1'b0, 4'sd1, 4'sd1);
        tick(); tick();
        step(1'b1, 1'b0, 1'b1, 4'sd0, 4'sd0);
        idle(2);
        check("hit_hit", int'(hit), 1);
        check("hit_active", int'(active), 0);
        check("hit_left", int'(left), 318);
        check("hit_top", int'(top), 2);
        step(1'b0, 1'b1, 1'b1, 4'sd3, 4'sd3);
        repeat (15) tick();
        check("hit15_hit", int'(hit), 1);
        tick();
        check("hit16_hit", int'(hit), 0);
        check("hit16_active", int'(active), 0);
        check("hit16_left", int'(left), 316);

        // reset in the middle of HIT
        do_reset();
        step(1'b0, 1'b1, 1'b0, 4'sd2, 4'sd2);
        tick();
        step(1'b0, 1'b0, 1'b1, 4'sd0, 4'sd0);
        idle(3);
        check("midhit_hit", int'(hit), 1);
        reset = 1'b1;
        #1;
        check_start_rect("midhit_rst");
        idle(2);
        check_start_rect("midhit_hold");
        reset = 1'b0;
        idle(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1);
    end

endmodule
